// File: rtl/tdm_demux8_if.sv
// tdm_demux8_if: TDM sample input and frame-coherent channel outputs of the demux
interface tdm_demux8_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0]      d;
    logic                  valid;
    logic                  sync;
    logic [7:0][WIDTH-1:0] y;
    logic [2:0]            s;
    logic                  frame_done;
    logic                  locked;
    logic                  err;
    modport master(output d, valid, sync, input y, s, frame_done, locked, err);
    modport slave(input d, valid, sync, output y, s, frame_done, locked, err);
endinterface

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive-side 8-channel TDM demultiplexer with HUNT/LOCK framing
module tdm_demux8 #(parameter int WIDTH = 1) (
    input logic          clk,
    input logic          rst,
    tdm_demux8_if.slave  bus
);
    typedef enum logic {HUNT, LOCK} state_t;
    state_t                state;
    logic [6:0][WIDTH-1:0] shadow;
    assign bus.locked = state == LOCK;
    // Framing FSM: collects channels 0..6 in shadow and loads all outputs together on channel 7
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= HUNT;
            shadow         <= '0;
            bus.y          <= '0;
            bus.s          <= '0;
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            bus.err        <= 1'b0;
            if (bus.valid) begin
                case (state)
                    HUNT: if (bus.sync) begin
                        shadow[0] <= bus.d;
                        bus.s     <= 3'd1;
                        state     <= LOCK;
                    end
                    LOCK: if (bus.sync) begin
                        shadow[0] <= bus.d;
                        bus.s     <= 3'd1;
                        bus.err   <= bus.s != 3'd0;
                    end else if (bus.s == 3'd0) begin
                        bus.err <= 1'b1;
                        state   <= HUNT;
                    end else if (bus.s == 3'd7) begin
                        bus.y          <= {bus.d, shadow};
                        bus.frame_done <= 1'b1;
                        bus.s          <= 3'd0;
                    end else begin
                        shadow[bus.s] <= bus.d;
                        bus.s         <= bus.s + 3'd1;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: directed and random stimulus checked against a queue-based frame model
module tb_tdm_demux8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    tdm_demux8_if #(.WIDTH(1)) bus();
    tdm_demux8 #(.WIDTH(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [7:0] m_y = '0;
    logic m_fd = 1'b0, m_err = 1'b0, m_lock = 1'b0;
    logic q[$];
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask
    task automatic step(input logic r, input logic v, input logic sy, input logic dd);
        rst = r;
        bus.valid = v;
        bus.sync = sy;
        bus.d = dd;
        @(posedge clk);
        m_fd = 1'b0;
        m_err = 1'b0;
        if (r) begin
            q.delete();
            m_y = '0;
            m_lock = 1'b0;
        end else if (v) begin
            if (!m_lock) begin
                if (sy) begin
                    q = {dd};
                    m_lock = 1'b1;
                end
            end else if (sy) begin
                m_err = q.size() != 0;
                q = {dd};
            end else if (q.size() == 0) begin
                m_err = 1'b1;
                m_lock = 1'b0;
            end else begin
                q.push_back(dd);
                if (q.size() == 8) begin
                    for (int i = 0; i < 8; i++) m_y[i] = q[i];
                    m_fd = 1'b1;
                    q.delete();
                end
            end
        end
        #1;
        chk("y", bus.y, m_y);
        chk("s", {5'd0, bus.s}, 8'(q.size()));
        chk("frame_done", {7'd0, bus.frame_done}, {7'd0, m_fd});
        chk("err", {7'd0, bus.err}, {7'd0, m_err});
        chk("locked", {7'd0, bus.locked}, {7'd0, m_lock});
    endtask
    task automatic send(input logic [7:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) step(1'b0, 1'b1, i == 0, bits[i]);
    endtask
    initial begin
        bus.valid = 1'b0;
        bus.sync = 1'b0;
        bus.d = '0;
        // reset held two cycles with VALID and SYNC high
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_y", bus.y, 8'h00);
        // single clean frame
        send(8'h4D, 0, 7);
        chk("frame_y", bus.y, 8'h4D);
        chk("frame_fd", {7'd0, bus.frame_done}, 8'h01);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // frame with gaps after ch2 and ch5
        send(8'hB2, 0, 2);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
        send(8'hB2, 3, 5);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        send(8'hB2, 6, 7);
        chk("gap_y", bus.y, 8'hB2);
        // early SYNC at ch4 then seven clean samples
        send(8'h0F, 0, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("early_err", {7'd0, bus.err}, 8'h01);
        chk("early_s", {5'd0, bus.s}, 8'h01);
        send(8'hA5, 1, 7);
        chk("early_y", bus.y, 8'hA5);
        // missing SYNC after a full frame, then relock
        send(8'h3C, 0, 7);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("miss_locked", {7'd0, bus.locked}, 8'h00);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b1);
        send(8'hC3, 0, 7);
        chk("relock_y", bus.y, 8'hC3);
        // reset arriving with ch5
        send(8'hFF, 0, 4);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("midrst_y", bus.y, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        // random traffic
        for (int n = 0; n < 1500; n++) begin
            logic v, sy, r;
            r = $urandom_range(0, 199) == 0;
            v = $urandom_range(0, 3) != 0;
            sy = (q.size() == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
            step(r, v, sy, 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
